approx_adder_err_monitor: RTL
=============================

// Module: approx_adder_err_monitor
// PURPOSE
//  Consumer-side checker for the approximate 8-bit adder datapath: takes operand pairs plus the
//  adder's approximate result over a valid/ready stream, recomputes the exact sum and accumulates
//  error statistics over a programmable sample window. Sits beside the adder in the characterisation
//  harness; results are read by the host after each window.
// PARAMETERS
//  WIDTH   8    operand width; approximate/exact sums are WIDTH+1 bits (carry-out included)
//  CNT_W   16   width of window length, sample counter and error counter
//  ACC_W   24   width of the error-distance accumulator
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        pulse: begin window (sampled only in IDLE)
//  win_len     in   CNT_W    samples per window, latched on start; 0 treated as 1
//  in_valid    in   1        operand/result beat valid
//  in_ready    out  1        monitor accepts beat; high only in RUN
//  op_a        in   WIDTH    operand A
//  op_b        in   WIDTH    operand B
//  approx_sum  in   WIDTH+1  approximate adder result {cout,sum}
//  res_valid   out  1        statistics valid (DONE)
//  res_ack     in   1        host consumed results; DONE -> IDLE
//  err_cnt     out  CNT_W    beats with nonzero error distance
//  ed_sum      out  ACC_W    sum of |exact - approx|, saturating
//  ed_max      out  WIDTH+1  largest error distance seen
//  busy        out  1        FSM not IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE; in_ready, res_valid, busy=0; err_cnt, ed_sum, ed_max, sample counter, pipe valids=0.
//  - FSM: IDLE --start--> RUN (latch win_len, clear statistics); RUN --last beat accepted--> DRAIN;
//    DRAIN --pipe empty--> DONE; DONE --res_ack--> IDLE. start outside IDLE ignored.
//  - Handshake: beat transfers when in_valid & in_ready; in_ready deasserts the cycle after the
//    win_len-th transfer (combinational: in_ready = RUN & (count < win_len)). No backpressure inside pipe.
//  - Pipeline, 2 stages: S1 registers op_a, op_b, approx_sum; S2 computes exact=op_a+op_b (WIDTH+1),
//    ed=|exact-approx_sum|, updates statistics. Statistics reflect a beat 2 cycles after transfer.
//  - Updates: ed!=0 -> err_cnt+=1; ed_sum+=ed, clamps at all-ones; ed_max=max(ed_max,ed).
//  - res_valid=1 only in DONE; outputs stable in DONE; start+res_ack same cycle in DONE: res_ack wins,
//    start ignored. start and res_ack in same cycle as reset release ignored.
//  - Async reset mid-window discards in-flight beats and statistics, returns to IDLE.
// CONFIGURATION
//  - ERR_HIST_EN defined: adds outputs hist0, hist1, hist23, hist4p (CNT_W each) counting beats with
//    ed==0, ed==1, ed in 2..3, ed>=4; cleared on start and reset, saturating; hist sum == win_len at DONE.
//  - Undefined: histogram ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package approx_adder_pkg: WIDTH default constant, FSM state typedef {IDLE,RUN,DRAIN,DONE},
//    saturating-add helper function.
//  - Sub-module approx_err_dist: combinational exact sum and absolute error distance, used in S2.
// TESTING
//  - Exact window: win_len=4, beats (10,5,15),(200,100,300),(0,0,0),(255,255,510) -> err_cnt=0, ed_sum=0, ed_max=0.
//  - Errors: win_len=3, (10,5,12),(3,3,7),(128,1,129) -> err_cnt=2, ed_sum=4, ed_max=3, res_valid after DRAIN.
//  - Backpressure: in_valid held high 10 cycles, win_len=5 -> exactly 5 transfers, in_ready low after 5th.
//  - Saturation: ACC_W=8 override, 3 beats ed=100 -> ed_sum=255.
//  - Control corners: start in RUN ignored; start+res_ack in DONE -> IDLE; rst_n low mid-RUN -> all outputs 0.
//  - ERR_HIST_EN: eds {0,1,2,3,5} -> hist0=1, hist1=1, hist23=2, hist4p=1.

Source files
------------

// File: rtl/approx_adder_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
// Provides the FSM state encoding and a generic saturating adder used by all counters.
`default_nettype none

package approx_adder_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Adds two values and clamps the result to the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/approx_err_dist.sv
// Combinational exact-sum recomputation and absolute error distance against
// the approximate adder's {cout,sum} result.
`default_nettype none

module approx_err_dist #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [WIDTH:0]   i_approx,
  output logic [WIDTH:0]   o_err_dist
);

  logic [WIDTH:0] w_exact;

  assign w_exact    = {1'b0, i_op_a} + {1'b0, i_op_b};
  assign o_err_dist = (w_exact >= i_approx) ? (w_exact - i_approx) : (i_approx - w_exact);

endmodule

`default_nettype wire

// File: rtl/approx_adder_err_monitor.sv
// Approximate-adder error monitor: accumulates error statistics over a programmable window.
// Define ERR_HIST_EN to add the hist0/hist1/hist23/hist4p error-distance histogram outputs.
`default_nettype none

module approx_adder_err_monitor
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [WIDTH:0]   ed_max,
  output logic             busy
`ifdef ERR_HIST_EN
  ,
  output logic [CNT_W-1:0] hist0,
  output logic [CNT_W-1:0] hist1,
  output logic [CNT_W-1:0] hist23,
  output logic [CNT_W-1:0] hist4p
`endif
);

  localparam logic [WIDTH:0] c_ED_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] c_ED_FOUR = (WIDTH+1)'(4);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_armed;
  logic [CNT_W-1:0] r_win_len;
  logic [CNT_W-1:0] r_count;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH:0]   r_s1_approx;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_ed_sum;
  logic [WIDTH:0]   r_ed_max;
  logic [WIDTH:0]   w_ed;
  logic             w_fire;
  logic             w_last;
  logic             w_clear;
  logic [CNT_W-1:0] w_win_len_eff;

  // r_armed keeps start/res_ack from acting on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_armed <= 1'b0;
    else        r_armed <= 1'b1;
  end

  assign w_win_len_eff = (win_len == '0) ? CNT_W'(1) : win_len;
  assign in_ready      = (r_state == RUN) && (r_count < r_win_len);
  assign w_fire        = in_valid && in_ready;
  assign w_last        = w_fire && (r_count == (r_win_len - CNT_W'(1)));
  assign w_clear       = (r_state == IDLE) && start && r_armed;
  assign res_valid     = (r_state == DONE);
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start && r_armed) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DRAIN;
      DRAIN:   if (!r_s1_valid) w_next_state = DONE;
      DONE:    if (res_ack && r_armed) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_len <= '0;
      r_count   <= '0;
    end else if (w_clear) begin
      r_win_len <= w_win_len_eff;
      r_count   <= '0;
    end else if (w_fire) begin
      r_count   <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_approx <= '0;
    end else begin
      r_s1_valid <= w_fire;
      if (w_fire) begin
        r_s1_a      <= op_a;
        r_s1_b      <= op_b;
        r_s1_approx <= approx_sum;
      end
    end
  end

  approx_err_dist #(
    .WIDTH (WIDTH)
  ) u_err_dist (
    .i_op_a     (r_s1_a),
    .i_op_b     (r_s1_b),
    .i_approx   (r_s1_approx),
    .o_err_dist (w_ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_ed_sum  <= '0;
      r_ed_max  <= '0;
    end else if (w_clear) begin
      r_err_cnt <= '0;
      r_ed_sum  <= '0;
      r_ed_max  <= '0;
    end else if (r_s1_valid) begin
      if (w_ed != '0) r_err_cnt <= CNT_W'(sat_add(32'(r_err_cnt), 32'd1, CNT_W));
      r_ed_sum <= ACC_W'(sat_add(32'(r_ed_sum), 32'(w_ed), ACC_W));
      if (w_ed > r_ed_max) r_ed_max <= w_ed;
    end
  end

  assign err_cnt = r_err_cnt;
  assign ed_sum  = r_ed_sum;
  assign ed_max  = r_ed_max;

`ifdef ERR_HIST_EN
  logic [CNT_W-1:0] r_hist0;
  logic [CNT_W-1:0] r_hist1;
  logic [CNT_W-1:0] r_hist23;
  logic [CNT_W-1:0] r_hist4p;

  // Bins: ed==0, ed==1, ed in 2..3, ed>=4; each beat lands in exactly one bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist0  <= '0;
      r_hist1  <= '0;
      r_hist23 <= '0;
      r_hist4p <= '0;
    end else if (w_clear) begin
      r_hist0  <= '0;
      r_hist1  <= '0;
      r_hist23 <= '0;
      r_hist4p <= '0;
    end else if (r_s1_valid) begin
      if (w_ed == '0)
        r_hist0 <= CNT_W'(sat_add(32'(r_hist0), 32'd1, CNT_W));
      else if (w_ed == c_ED_ONE)
        r_hist1 <= CNT_W'(sat_add(32'(r_hist1), 32'd1, CNT_W));
      else if (w_ed < c_ED_FOUR)
        r_hist23 <= CNT_W'(sat_add(32'(r_hist23), 32'd1, CNT_W));
      else
        r_hist4p <= CNT_W'(sat_add(32'(r_hist4p), 32'd1, CNT_W));
    end
  end

  assign hist0  = r_hist0;
  assign hist1  = r_hist1;
  assign hist23 = r_hist23;
  assign hist4p = r_hist4p;
`endif

endmodule

`default_nettype wire
